// File: rtl/opc_intc_pkg.sv
// Shared definitions for the OPC interrupt controller: register offsets,
// FSM state encoding and the spurious-vector helper.
package opc_intc_pkg;

  localparam logic [2:0] INTC_MASK = 3'd0;
  localparam logic [2:0] INTC_EDGE = 3'd1;
  localparam logic [2:0] INTC_PEND = 3'd2;
  localparam logic [2:0] INTC_INSV = 3'd3;
  localparam logic [2:0] INTC_VEC  = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } intc_state_t;

  // Vector returned when the CPU acknowledges with nothing requested:
  // the slot immediately after the last real channel.
  function automatic logic [15:0] spurious_vec(input logic [15:0] base,
                                               input int nchan,
                                               input int stride);
    return 16'(32'(base) + 32'(nchan * stride));
  endfunction

endpackage

// File: rtl/opc_intc_if.sv
// CPU I/O-space register bus for the interrupt controller.
interface opc_intc_if;
  logic        io_sel;
  logic        io_rnw;
  logic [2:0]  io_addr;
  logic [15:0] io_din;
  logic [15:0] io_dout;

  modport master (output io_sel, io_rnw, io_addr, io_din, input io_dout);
  modport slave  (input io_sel, io_rnw, io_addr, io_din, output io_dout);
endinterface

// File: rtl/opc_intc_sync.sv
// Two-flop synchroniser for one active-low interrupt line, plus a third
// flop holding the previous synchronised value for falling-edge detection.
module opc_intc_sync (
  input  logic clk,
  input  logic reset,
  input  logic clken,
  input  logic irq_b,
  output logic sync_b,
  output logic fall
);
  logic s0_q, s1_q, s2_q;
  logic s0_d, s1_d, s2_d;

  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    s2_d = s2_q;
    if (clken) begin
      s0_d = irq_b;
      s1_d = s0_q;
      s2_d = s1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign sync_b = s1_q;
  assign fall   = ~s1_q & s2_q;
endmodule

// File: rtl/opc_intc.sv
// Prioritised NCHAN-channel interrupt controller for the OPC CPU.
// Define OPC_INTC_NEST_EN to allow higher-priority channels to preempt.
module opc_intc
  import opc_intc_pkg::*;
#(
  parameter int          NCHAN         = 8,
  parameter logic [15:0] VECTOR_BASE   = 16'h0002,
  parameter int          VECTOR_STRIDE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clken,
  input  logic [NCHAN-1:0] irq_b,
  output logic             int_o_b,
  input  logic             int_ack,
  input  logic             eoi,
  output logic [15:0]      vector,
  opc_intc_if.slave        io
);

  logic [NCHAN-1:0] sync_b, fall;
  logic [NCHAN-1:0] mask_q, mask_d, edge_q, edge_d;
  logic [NCHAN-1:0] pend_q, pend_d, insv_q, insv_d;
  logic [NCHAN-1:0] elig, pend_clr, insv_clr, insv_set, cur_bit, eoi_lowest;
  logic [15:0]      elig16, cur_onehot16;
  logic [15:0]      vec_q, vec_d, vector_q, vector_d, vec_calc, dout_w;
  logic [3:0]       cur_q, cur_d, idx;
  logic             any_elig, wr, int_o_b_q, int_o_b_d;
  intc_state_t      state_q, state_d;
  logic             unused_bits;

  generate
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
      opc_intc_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .clken  (clken),
        .irq_b  (irq_b[gi]),
        .sync_b (sync_b[gi]),
        .fall   (fall[gi])
      );
`ifdef OPC_INTC_NEST_EN
      assign elig[gi] = pend_q[gi] & mask_q[gi] & ~|insv_q[gi:0];
`else
      assign elig[gi] = pend_q[gi] & mask_q[gi] & ~|insv_q;
`endif
    end
  endgenerate

  // Lowest index wins: scan from the top so the last hit is the winner.
  always_comb begin
    idx = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (elig[i]) idx = 4'(i);
    end
  end

  always_comb begin
    elig16 = '0;
    elig16[NCHAN-1:0] = elig;
  end

  assign any_elig     = |elig;
  assign vec_calc     = 16'(32'(VECTOR_BASE) + 32'(idx) * VECTOR_STRIDE);
  assign cur_onehot16 = 16'd1 << cur_q;
  assign cur_bit      = cur_onehot16[NCHAN-1:0];
  assign eoi_lowest   = insv_q & (~insv_q + NCHAN'(1));
  assign wr           = io.io_sel & ~io.io_rnw & clken;

  always_comb begin
    mask_d    = mask_q;
    edge_d    = edge_q;
    pend_d    = pend_q;
    insv_d    = insv_q;
    vec_d     = vec_q;
    vector_d  = vector_q;
    cur_d     = cur_q;
    state_d   = state_q;
    int_o_b_d = int_o_b_q;
    pend_clr  = '0;
    insv_clr  = '0;
    insv_set  = '0;
    if (clken) begin
      if (wr) begin
        case (io.io_addr)
          INTC_MASK: mask_d   = io.io_din[NCHAN-1:0];
          INTC_EDGE: edge_d   = io.io_din[NCHAN-1:0];
          INTC_PEND: pend_clr = io.io_din[NCHAN-1:0] & edge_q;
          default: ;
        endcase
      end
      if (eoi) insv_clr = eoi_lowest;
      case (state_q)
        IDLE: begin
          if (int_ack) vector_d = spurious_vec(VECTOR_BASE, NCHAN, VECTOR_STRIDE);
          if (any_elig) begin
            state_d = REQ;
            cur_d   = idx;
            vec_d   = vec_calc;
          end
        end
        REQ: begin
          if (int_ack) begin
            state_d  = IDLE;
            insv_set = cur_bit;
            pend_clr = pend_clr | (cur_bit & edge_q);
            vector_d = vec_q;
          end else if (!elig16[cur_q]) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      // A fresh edge outranks any clear on the same cycle.
      pend_d    = (((pend_q & ~pend_clr) | fall) & edge_q) | (~sync_b & ~edge_q);
      insv_d    = (insv_q & ~insv_clr) | insv_set;
      int_o_b_d = (state_d != REQ);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q    <= '0;
      edge_q    <= '0;
      pend_q    <= '0;
      insv_q    <= '0;
      vec_q     <= VECTOR_BASE;
      vector_q  <= VECTOR_BASE;
      cur_q     <= '0;
      state_q   <= IDLE;
      int_o_b_q <= 1'b1;
    end else begin
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      pend_q    <= pend_d;
      insv_q    <= insv_d;
      vec_q     <= vec_d;
      vector_q  <= vector_d;
      cur_q     <= cur_d;
      state_q   <= state_d;
      int_o_b_q <= int_o_b_d;
    end
  end

  always_comb begin
    dout_w = '0;
    case (io.io_addr)
      INTC_MASK: dout_w[NCHAN-1:0] = mask_q;
      INTC_EDGE: dout_w[NCHAN-1:0] = edge_q;
      INTC_PEND: dout_w[NCHAN-1:0] = pend_q;
      INTC_INSV: dout_w[NCHAN-1:0] = insv_q;
      INTC_VEC:  dout_w            = vec_q;
      default:   dout_w            = '0;
    endcase
  end

  assign io.io_dout  = dout_w;
  assign int_o_b     = int_o_b_q;
  assign vector      = vector_q;
  assign unused_bits = &{1'b0, io.io_din, cur_onehot16, elig16};

endmodule

// File: tb/tb_opc_intc.sv
// Directed self-checking bench for opc_intc with a vector scoreboard.
`timescale 1ns/1ps
module tb_opc_intc;
  localparam int NCHAN = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             clken;
  logic [NCHAN-1:0] irq_b;
  logic             int_o_b;
  logic             int_ack;
  logic             eoi;
  logic [15:0]      vector;

  int tests  = 0;
  int failed = 0;
  logic [15:0] exp_q[$];

  opc_intc_if io_bus ();

  opc_intc #(.NCHAN(NCHAN), .VECTOR_BASE(16'h0002), .VECTOR_STRIDE(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .clken   (clken),
    .irq_b   (irq_b),
    .int_o_b (int_o_b),
    .int_ack (int_ack),
    .eoi     (eoi),
    .vector  (vector),
    .io      (io_bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic io_write(input logic [2:0] addr, input logic [15:0] data);
    io_bus.io_sel  = 1'b1;
    io_bus.io_rnw  = 1'b0;
    io_bus.io_addr = addr;
    io_bus.io_din  = data;
    tick();
    io_bus.io_sel  = 1'b0;
    io_bus.io_rnw  = 1'b1;
  endtask

  task automatic io_read(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    io_bus.io_sel  = 1'b1;
    io_bus.io_rnw  = 1'b1;
    io_bus.io_addr = addr;
    #1;
    chk(tag, io_bus.io_dout, exp);
    io_bus.io_sel  = 1'b0;
  endtask

  task automatic pulse_irq(input logic [NCHAN-1:0] bits);
    irq_b = irq_b & ~bits;
    tick();
    irq_b = irq_b | bits;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int max);
    int n = 0;
    while (int_o_b === 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, int_o_b}, 32'd0);
  endtask

  task automatic do_ack(input string tag);
    logic [15:0] exp;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    if (exp_q.size() == 0) begin
      tests++;
      failed++;
      $error("FAIL %s: scoreboard empty, observed vector %0h", tag, vector);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, {16'd0, vector}, {16'd0, exp});
    end
    chk({tag, "_intob"}, {31'd0, int_o_b}, 32'd1);
  endtask

  initial begin
    reset          = 1'b1;
    clken          = 1'b1;
    irq_b          = '1;
    int_ack        = 1'b0;
    eoi            = 1'b0;
    io_bus.io_sel  = 1'b0;
    io_bus.io_rnw  = 1'b1;
    io_bus.io_addr = 3'd0;
    io_bus.io_din  = 16'd0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    chk("rst_intob", {31'd0, int_o_b}, 32'd1);
    chk("rst_vector", {16'd0, vector}, 32'h0002);
    io_read("rst_mask", 3'd0, 16'h0000);
    io_read("rst_edge", 3'd1, 16'h0000);
    io_read("rst_pend", 3'd2, 16'h0000);
    io_read("rst_insv", 3'd3, 16'h0000);

    // Edge channel 3: exact three-edge latency.
    io_write(3'd0, 16'h0008);
    io_write(3'd1, 16'h0008);
    exp_q.push_back(16'h0008);
    pulse_irq(8'h08);
    chk("e3_k", {31'd0, int_o_b}, 32'd1);
    tick();
    chk("e3_k1", {31'd0, int_o_b}, 32'd1);
    tick();
    chk("e3_k2", {31'd0, int_o_b}, 32'd1);
    io_read("e3_pend_set", 3'd2, 16'h0008);
    tick();
    chk("e3_k3", {31'd0, int_o_b}, 32'd0);
    do_ack("e3_ack");
    io_read("e3_insv", 3'd3, 16'h0008);
    io_read("e3_pend", 3'd2, 16'h0000);
    pulse_eoi();
    io_read("e3_eoi", 3'd3, 16'h0000);

    // Channel 5 in service, then channel 1 arrives.
    io_write(3'd0, 16'h0022);
    io_write(3'd1, 16'h0022);
    exp_q.push_back(16'h000C);
    pulse_irq(8'h20);
    wait_req("n5_req", 10);
    do_ack("n5_ack");
    io_read("n5_insv", 3'd3, 16'h0020);
    exp_q.push_back(16'h0004);
    pulse_irq(8'h02);
`ifdef OPC_INTC_NEST_EN
    wait_req("n1_req", 10);
    do_ack("n1_ack");
    io_read("n1_insv", 3'd3, 16'h0022);
    pulse_eoi();
    io_read("n1_eoi", 3'd3, 16'h0020);
    pulse_eoi();
`else
    repeat (8) tick();
    chk("n1_blocked", {31'd0, int_o_b}, 32'd1);
    io_read("n1_pend", 3'd2, 16'h0002);
    pulse_eoi();
    io_read("n5_eoi", 3'd3, 16'h0000);
    wait_req("n1_req", 10);
    do_ack("n1_ack");
    io_read("n1_insv", 3'd3, 16'h0002);
    pulse_eoi();
`endif
    io_read("n_insv_clr", 3'd3, 16'h0000);

    // Level channel 2 withdrawn by masking and release while requesting.
    io_write(3'd1, 16'h0000);
    io_write(3'd0, 16'h0004);
    irq_b[2] = 1'b0;
    wait_req("l2_req", 10);
    irq_b[2] = 1'b1;
    io_write(3'd0, 16'h0000);
    tick();
    chk("l2_withdraw", {31'd0, int_o_b}, 32'd1);
    exp_q.push_back(16'h0012);
    do_ack("l2_spurious");
    io_read("l2_insv", 3'd3, 16'h0000);

    // Channels 6 and 4 pending together.
    io_write(3'd1, 16'h0050);
    io_write(3'd0, 16'h0050);
    exp_q.push_back(16'h000A);
    pulse_irq(8'h50);
    wait_req("p4_req", 10);
    do_ack("p4_ack");
    io_read("p4_insv", 3'd3, 16'h0010);
    io_read("p6_pend", 3'd2, 16'h0040);
    pulse_eoi();
    exp_q.push_back(16'h000E);
    wait_req("p6_req", 10);
    do_ack("p6_ack");
    pulse_eoi();
    io_read("p_vecreg", 3'd4, 16'h000E);

    // W1C on edge vs level pending bits.
    io_write(3'd0, 16'h0000);
    io_write(3'd1, 16'h0001);
    irq_b[7] = 1'b0;
    pulse_irq(8'h01);
    repeat (4) tick();
    io_read("w_pend", 3'd2, 16'h0081);
    io_write(3'd2, 16'h0081);
    io_read("w_pend_w1c", 3'd2, 16'h0080);
    irq_b[7] = 1'b1;
    repeat (4) tick();
    io_read("w_pend_rel", 3'd2, 16'h0000);
    chk("w_intob", {31'd0, int_o_b}, 32'd1);
    io_read("r_off5", 3'd5, 16'h0000);
    io_read("r_off6", 3'd6, 16'h0000);
    io_read("r_off7", 3'd7, 16'h0000);

    // Asynchronous reset while requesting.
    io_write(3'd0, 16'h0001);
    io_write(3'd1, 16'h0001);
    pulse_irq(8'h01);
    wait_req("r_req", 10);
    #2;
    reset = 1'b1;
    #1;
    chk("r_intob", {31'd0, int_o_b}, 32'd1);
    chk("r_vector", {16'd0, vector}, 32'h0002);
    io_read("r_mask", 3'd0, 16'h0000);
    io_read("r_edge", 3'd1, 16'h0000);
    io_read("r_pend", 3'd2, 16'h0000);
    io_read("r_insv", 3'd3, 16'h0000);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("r_idle", {31'd0, int_o_b}, 32'd1);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
